brief_key_scheduler: RTL

//  Parametrised keypoint scheduler between the orientation stage and the BRIEF descriptor unit.

---
 rtl/brief_key_scheduler_pkg.sv | 21 ++
 rtl/brief_key_scheduler_if.sv | 36 +++
 rtl/brief_key_scheduler_fifo.sv | 39 +++
 rtl/brief_key_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/brief_key_scheduler_pkg.sv
// Shared types and size helpers for the BRIEF keypoint scheduler.
package brief_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WORK, S_DRAIN} state_t;

   function automatic int half_of(input int patch);
      return patch / 2;
   endfunction

   // Pixels that must be in the line buffer before the window centre sits at (0,0).
   function automatic int lag_of(input int width, input int patch);
      return (patch / 2) * width + patch / 2;
   endfunction

   function automatic int keyw_of(input int xw, input int yw, input int aw);
      return xw + yw + 2 * aw;
   endfunction

   localparam int KEYW = keyw_of(10, 10, 12);

endpackage

// File: rtl/brief_key_scheduler_if.sv
// Keypoint push / frame control / centre and hit outputs of the scheduler.
interface brief_key_scheduler_if #(
   parameter int XW = 10,
   parameter int YW = 10,
   parameter int AW = 12
);
   logic                 i_start;
   logic                 i_pix_valid;
   logic                 i_key_valid;
   logic [XW-1:0]        i_key_x;
   logic [YW-1:0]        i_key_y;
   logic signed [AW-1:0] i_key_sin;
   logic signed [AW-1:0] i_key_cos;
   logic                 o_ctr_valid;
   logic [XW-1:0]        o_ctr_x;
   logic [YW-1:0]        o_ctr_y;
   logic                 o_hit;
   logic signed [AW-1:0] o_sin;
   logic signed [AW-1:0] o_cos;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_overflow;
   logic [15:0]          o_drop_cnt;

   modport master (
      output i_start, i_pix_valid, i_key_valid, i_key_x, i_key_y, i_key_sin, i_key_cos,
      input  o_ctr_valid, o_ctr_x, o_ctr_y, o_hit, o_sin, o_cos, o_busy, o_done,
             o_overflow, o_drop_cnt
   );

   modport slave (
      input  i_start, i_pix_valid, i_key_valid, i_key_x, i_key_y, i_key_sin, i_key_cos,
      output o_ctr_valid, o_ctr_x, o_ctr_y, o_hit, o_sin, o_cos, o_busy, o_done,
             o_overflow, o_drop_cnt
   );
endinterface

// File: rtl/brief_key_scheduler_fifo.sv
// Keypoint FIFO with combinational head look-ahead; caller guarantees no push
// when full without a simultaneous pop, and no pop when empty.
module brief_key_fifo #(
   parameter int DEPTH = 128,
   parameter int W     = 44
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wp, rp;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en) wp <= wp + 1'b1;
         if (rd_en) rp <= rp + 1'b1;
      end
   end

   // Full-queue push+pop lands in the slot being vacated; the head is read before the edge.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wp[PW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rp[PW-1:0]];
   assign empty   = (wp == rp);
   assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
endmodule

// File: rtl/brief_key_scheduler.sv
// Keypoint scheduler: tracks the line-buffer window centre and pops queued keypoints
// as the centre reaches them. Define BRIEF_BORDER_FILTER_EN to reject border keypoints at push.
module brief_key_scheduler
   import brief_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int PATCH  = 31,
   parameter int DEPTH  = 128,
   parameter int XW     = 10,
   parameter int YW     = 10,
   parameter int AW     = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   brief_key_scheduler_if.slave  bus
);
   localparam int LAG  = lag_of(WIDTH, PATCH);
   localparam int NPIX = WIDTH * HEIGHT;
   localparam int CW   = $clog2(NPIX + 1);
   localparam int KW   = keyw_of(XW, YW, AW);

   typedef struct packed {
      logic [YW-1:0]        y;
      logic [XW-1:0]        x;
      logic signed [AW-1:0] s;
      logic signed [AW-1:0] c;
   } key_t;

   state_t        state, state_nx;
   logic [CW-1:0] pix_cnt;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic          ctr_vld, done_q, ovf_q;
   logic [15:0]   drop_q;
   logic          clr, emit, step, pix_inc, done_nx, at_last;

   key_t          push_key, head;
   logic [KW-1:0] head_raw;
   logic          full, empty, pass, push_ok, lost, filt, hit, stale, pop;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum;

   assign at_last = (cx == XW'(WIDTH - 1)) && (cy == YW'(HEIGHT - 1));

   always_comb begin
      state_nx = state;
      clr      = 1'b0;
      emit     = 1'b0;
      pix_inc  = 1'b0;
      done_nx  = 1'b0;
      case (state)
         S_IDLE: if (bus.i_start) begin
            clr      = 1'b1;
            state_nx = S_FILL;
         end
         S_FILL: if (bus.i_pix_valid) begin
            pix_inc = 1'b1;
            if (pix_cnt == CW'(LAG)) begin
               emit     = 1'b1;
               state_nx = S_WORK;
            end
         end
         S_WORK: begin
            if (pix_cnt == CW'(NPIX)) begin
               state_nx = S_DRAIN;
            end else if (bus.i_pix_valid) begin
               pix_inc = 1'b1;
               emit    = 1'b1;
            end
         end
         S_DRAIN: begin
            if (at_last) begin
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               emit = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // The first centre is the (0,0) already loaded by the frame start, so FILL emits without stepping.
   assign step = emit && (state != S_FILL);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pix_cnt <= '0;
         cx      <= '0;
         cy      <= '0;
         ctr_vld <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         ctr_vld <= emit;
         done_q  <= done_nx;
         ovf_q   <= (ovf_q & ~clr) | lost;
         drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (clr)          pix_cnt <= '0;
         else if (pix_inc) pix_cnt <= pix_cnt + CW'(1);
         if (clr) begin
            cx <= '0;
            cy <= '0;
         end else if (step) begin
            if (cx == XW'(WIDTH - 1)) begin
               cx <= '0;
               cy <= cy + YW'(1);
            end else begin
               cx <= cx + XW'(1);
            end
         end
      end
   end

   assign push_key = '{y: bus.i_key_y, x: bus.i_key_x, s: bus.i_key_sin, c: bus.i_key_cos};

`ifdef BRIEF_BORDER_FILTER_EN
   localparam int HALF = half_of(PATCH);
   assign pass = (bus.i_key_x >= XW'(HALF)) && (bus.i_key_x <= XW'(WIDTH - 1 - HALF)) &&
                 (bus.i_key_y >= YW'(HALF)) && (bus.i_key_y <= YW'(HEIGHT - 1 - HALF));
`else
   assign pass = 1'b1;
`endif

   brief_key_fifo #(.DEPTH(DEPTH), .W(KW)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (push_ok),
      .wr_data (push_key),
      .rd_en   (pop),
      .rd_data (head_raw),
      .full    (full),
      .empty   (empty)
   );

   assign head = key_t'(head_raw);

   // Raster order compared row-first, so no multiply is needed for the index.
   assign hit   = ctr_vld && !empty && (head.y == cy) && (head.x == cx);
   assign stale = ctr_vld && !empty && ((head.y < cy) || ((head.y == cy) && (head.x < cx)));
   assign pop   = hit | stale;

   assign push_ok = bus.i_key_valid && pass && (!full || pop);
   assign lost    = bus.i_key_valid && pass && full && !pop;
   assign filt    = bus.i_key_valid && !pass;

   assign drop_inc = {1'b0, stale} + {1'b0, lost} + {1'b0, filt};
   assign drop_sum = {1'b0, (clr ? 16'd0 : drop_q)} + 17'(drop_inc);

   assign bus.o_ctr_valid = ctr_vld;
   assign bus.o_ctr_x     = cx;
   assign bus.o_ctr_y     = cy;
   assign bus.o_hit       = hit;
   assign bus.o_sin       = hit ? head.s : '0;
   assign bus.o_cos       = hit ? head.c : '0;
   assign bus.o_busy      = (state != S_IDLE);
   assign bus.o_done      = done_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_drop_cnt  = drop_q;
endmodule
